dot_product_stream: RTL

Streaming, parametrised dot-product engine: accumulates the dot product of two vectors delivered as multiple LANES-wide beats over a valid/ready input stream. Supports signed or unsigned elements and saturates the result. Presents the result on a valid/ready output. Sits between the vector FIFOs and the result sink, and takes the place of the fixed single-beat dot-product stage.

---
 rtl/dot_product_stream_if.sv | 31 +++
 rtl/dot_product_stream.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dot_product_stream_if.sv
// Stream bundle between the vector FIFOs, the dot-product engine and the result sink.
// master = FIFO/sink side, slave = the engine.
interface dot_product_stream_if #(
  parameter int unsigned ELEM_WIDTH   = 8,
  parameter int unsigned LANES        = 4,
  parameter int unsigned LEN_WIDTH    = 4,
  parameter int unsigned RESULT_WIDTH = 32
) ();
  logic                          start;
  logic [LEN_WIDTH-1:0]          vec_len;
  logic                          signed_mode;
  logic [LANES*ELEM_WIDTH-1:0]   a_data;
  logic [LANES*ELEM_WIDTH-1:0]   b_data;
  logic                          in_valid;
  logic                          in_ready;
  logic [RESULT_WIDTH-1:0]       result;
  logic                          overflow;
  logic                          out_valid;
  logic                          out_ready;
  logic                          busy;

  modport master (
    output start, vec_len, signed_mode, a_data, b_data, in_valid, out_ready,
    input  in_ready, result, overflow, out_valid, busy
  );

  modport slave (
    input  start, vec_len, signed_mode, a_data, b_data, in_valid, out_ready,
    output in_ready, result, overflow, out_valid, busy
  );
endinterface

// File: rtl/dot_product_stream.sv
// Multi-beat streaming dot product: a two-stage multiply/accumulate pipeline that
// saturates the final sum and holds it on a valid/ready output.
module dot_product_stream #(
  parameter int unsigned ELEM_WIDTH   = 8,
  parameter int unsigned LANES        = 4,
  parameter int unsigned LEN_WIDTH    = 4,
  parameter int unsigned RESULT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  dot_product_stream_if.slave   bus
);

  localparam int unsigned ACC_W  = 2*ELEM_WIDTH + $clog2(LANES) + LEN_WIDTH + 1;
  localparam int unsigned PROD_W = 2*ELEM_WIDTH + 2;
  localparam int unsigned CMP_W  = ((ACC_W > RESULT_WIDTH) ? ACC_W : RESULT_WIDTH) + 2;

  localparam logic signed [CMP_W-1:0] SMAX = {{(CMP_W-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SMIN = {{(CMP_W-RESULT_WIDTH+1){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};
  localparam logic signed [CMP_W-1:0] UMAX = {{(CMP_W-RESULT_WIDTH){1'b0}}, {RESULT_WIDTH{1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FLUSH1, S_FLUSH2, S_DONE} state_t;

  state_t                   r_state;
  logic [LEN_WIDTH-1:0]     r_len;
  logic [LEN_WIDTH-1:0]     r_beats;
  logic                     r_signed;
  logic                     r_p1_valid;
  logic signed [ACC_W-1:0]  r_prod [LANES];
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_busy;
  logic [RESULT_WIDTH-1:0]  r_result;
  logic                     r_overflow;

  logic signed [ELEM_WIDTH:0]   w_a_ext [LANES];
  logic signed [ELEM_WIDTH:0]   w_b_ext [LANES];
  logic signed [PROD_W-1:0]     w_prod  [LANES];
  logic signed [ACC_W-1:0]      w_lane_sum;
  logic signed [CMP_W-1:0]      w_acc_ext;
  logic [RESULT_WIDTH-1:0]      w_sat;
  logic                         w_sat_ovf;
  logic                         w_accept;
  logic                         w_last;

  // Each element gets one extra bit: a copy of its MSB in signed mode, zero otherwise,
  // so one signed multiplier covers both element formats.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_a_ext[k] = {r_signed & bus.a_data[k*ELEM_WIDTH + ELEM_WIDTH - 1], bus.a_data[k*ELEM_WIDTH +: ELEM_WIDTH]};
      w_b_ext[k] = {r_signed & bus.b_data[k*ELEM_WIDTH + ELEM_WIDTH - 1], bus.b_data[k*ELEM_WIDTH +: ELEM_WIDTH]};
      w_prod[k]  = PROD_W'(w_a_ext[k]) * PROD_W'(w_b_ext[k]);
    end
  end

  always_comb begin
    w_lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane_sum = w_lane_sum + r_prod[k];
    end
  end

  // Clamp the accumulator into the result range of the latched element mode.
  always_comb begin
    w_acc_ext = {{(CMP_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    w_sat     = RESULT_WIDTH'(w_acc_ext);
    w_sat_ovf = 1'b0;
    if (r_signed) begin
      if (w_acc_ext > SMAX) begin
        w_sat     = RESULT_WIDTH'(SMAX);
        w_sat_ovf = 1'b1;
      end else if (w_acc_ext < SMIN) begin
        w_sat     = RESULT_WIDTH'(SMIN);
        w_sat_ovf = 1'b1;
      end
    end else begin
      if (w_acc_ext[CMP_W-1]) begin
        w_sat     = '0;
        w_sat_ovf = 1'b1;
      end else if (w_acc_ext > UMAX) begin
        w_sat     = RESULT_WIDTH'(UMAX);
        w_sat_ovf = 1'b1;
      end
    end
  end

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_last   = (r_beats == r_len - LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_beats     <= '0;
      r_signed    <= 1'b0;
      r_p1_valid  <= 1'b0;
      r_acc       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      for (int k = 0; k < LANES; k++) r_prod[k] <= '0;
    end else begin
      r_p1_valid <= 1'b0;
      if (r_p1_valid) r_acc <= r_acc + w_lane_sum;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_len      <= bus.vec_len;
            r_signed   <= bus.signed_mode;
            r_acc      <= '0;
            r_beats    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            if (bus.vec_len == '0) begin
              r_state <= S_FLUSH1;
            end else begin
              r_state    <= S_ACCUM;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_p1_valid <= 1'b1;
            r_beats    <= r_beats + LEN_WIDTH'(1);
            for (int k = 0; k < LANES; k++) r_prod[k] <= ACC_W'(w_prod[k]);
            if (w_last) begin
              r_state    <= S_FLUSH1;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_FLUSH1: r_state <= S_FLUSH2;
        S_FLUSH2: begin
          r_result    <= w_sat;
          r_overflow  <= w_sat_ovf;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.result    = r_result;
  assign bus.overflow  = r_overflow;

endmodule
